// File: rtl/mcse_gpio_pkg.sv
// Shared constants for the GPIO register responder: register map,
// packet field positions and reset values.
package mcse_gpio_pkg;

   localparam logic [7:0] OFF_DIR    = 8'h00;
   localparam logic [7:0] OFF_OUT    = 8'h04;
   localparam logic [7:0] OFF_IN     = 8'h08;
   localparam logic [7:0] OFF_IMASK  = 8'h0C;
   localparam logic [7:0] OFF_IPOL   = 8'h10;
   localparam logic [7:0] OFF_ILAT   = 8'h14;
   localparam logic [7:0] OFF_OUTSET = 8'h18;
   localparam logic [7:0] OFF_OUTCLR = 8'h1C;

   localparam int WR_LSB   = 0;
   localparam int ADDR_LSB = 8;

   // IMASK comes out of reset with every pin masked
   localparam logic IMASK_RST = 1'b1;

   function automatic int data_lsb(input int aw);
      return aw + ADDR_LSB;
   endfunction

   typedef struct packed {
      logic dir;
      logic out;
      logic inp;
      logic imask;
      logic ipol;
      logic ilat;
      logic oset;
      logic oclr;
   } gpio_sel_t;

endpackage

// File: rtl/mcse_gpio_responder_sync.sv
// Three-stage pad synchronizer with rise/fall detection between the
// second and third stages.
module gpio_input_sync #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] din_i,
   output logic [N-1:0] sync_o,
   output logic [N-1:0] rise_o,
   output logic [N-1:0] fall_o
);

   logic [N-1:0] s1_q, s2_q, s3_q;
   logic [2:0]   arm_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q  <= '0;
         s2_q  <= '0;
         s3_q  <= '0;
         arm_q <= '0;
      end else begin
         s1_q  <= din_i;
         s2_q  <= s1_q;
         s3_q  <= s2_q;
         arm_q <= {arm_q[1:0], 1'b1};
      end
   end

   // edges only count once stage 3 holds a real pad sample
   assign sync_o = s2_q;
   assign rise_o = arm_q[2] ? (s2_q & ~s3_q) : '0;
   assign fall_o = arm_q[2] ? (~s2_q & s3_q) : '0;

endmodule

// File: rtl/mcse_gpio_responder.sv
// GPIO register block: packet decode, register file, interrupt latch
// and registered read-back.
module mcse_gpio_responder
   import mcse_gpio_pkg::*;
#(
   parameter int gpio_N  = 32,
   parameter int gpio_AW = 32,
   parameter int gpio_PW = 2*gpio_AW+40
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               gpio_reg_access,
   input  logic [gpio_PW-1:0] gpio_reg_packet,
   output logic [gpio_N-1:0]  gpio_reg_rdata,
   output logic               gpio_reg_rvalid,
   input  logic [gpio_N-1:0]  gpio_in,
   output logic [gpio_N-1:0]  gpio_out,
   output logic [gpio_N-1:0]  gpio_en,
   output logic [gpio_N-1:0]  gpio_ilat,
   output logic               gpio_irq
);

   localparam int DLSB = data_lsb(gpio_AW);

   logic               wr;
   logic [gpio_AW-1:0] addr;
   logic [gpio_N-1:0]  wdata;
   logic               pkt_unused;
   logic               wen, ren;
   gpio_sel_t          sel;
   logic [gpio_N-1:0]  rd_val;
   logic [gpio_N-1:0]  in_sync, rise, fall, edge_hit;

   logic [gpio_N-1:0] dir_q, dir_d, out_q, out_d;
   logic [gpio_N-1:0] imask_q, imask_d, ipol_q, ipol_d;
   logic [gpio_N-1:0] ilat_q, ilat_d, rdata_q, rdata_d;
   logic              irq_q, irq_d, rvalid_q, rvalid_d;

   assign wr         = gpio_reg_packet[WR_LSB];
   assign addr       = gpio_reg_packet[ADDR_LSB +: gpio_AW];
   assign wdata      = gpio_reg_packet[DLSB +: gpio_N];
   assign pkt_unused = ^gpio_reg_packet;
   assign wen        = gpio_reg_access & wr;
   assign ren        = gpio_reg_access & ~wr;

   gpio_input_sync #(.N(gpio_N)) u_sync (
      .clk    (clk),
      .rst    (rst),
      .din_i  (gpio_in),
      .sync_o (in_sync),
      .rise_o (rise),
      .fall_o (fall)
   );

   assign edge_hit = (rise & ipol_q) | (fall & ~ipol_q);

   always_comb begin
      sel = '0;
      if (addr[gpio_AW-1:8] == '0) begin
         case (addr[7:0])
            OFF_DIR:    sel.dir   = 1'b1;
            OFF_OUT:    sel.out   = 1'b1;
            OFF_IN:     sel.inp   = 1'b1;
            OFF_IMASK:  sel.imask = 1'b1;
            OFF_IPOL:   sel.ipol  = 1'b1;
            OFF_ILAT:   sel.ilat  = 1'b1;
            OFF_OUTSET: sel.oset  = 1'b1;
            OFF_OUTCLR: sel.oclr  = 1'b1;
            default:    sel       = '0;
         endcase
      end
   end

   always_comb begin
      rd_val = '0;
      unique case (1'b1)
         sel.dir:   rd_val = dir_q;
         sel.out:   rd_val = out_q;
         sel.inp:   rd_val = in_sync;
         sel.imask: rd_val = imask_q;
         sel.ipol:  rd_val = ipol_q;
         sel.ilat:  rd_val = ilat_q;
         default:   rd_val = '0;
      endcase
   end

   always_comb begin
      dir_d   = (wen && sel.dir)   ? wdata : dir_q;
      imask_d = (wen && sel.imask) ? wdata : imask_q;
      ipol_d  = (wen && sel.ipol)  ? wdata : ipol_q;
      out_d   = out_q;
      if (wen && sel.out)  out_d = wdata;
      if (wen && sel.oset) out_d = out_q | wdata;
      if (wen && sel.oclr) out_d = out_q & ~wdata;
      // a fresh edge wins over a same-cycle clear
      ilat_d   = (ilat_q & ~((wen && sel.ilat) ? wdata : '0)) | edge_hit;
      irq_d    = |(ilat_q & ~imask_q);
      rdata_d  = ren ? rd_val : rdata_q;
      rvalid_d = ren;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dir_q    <= '0;
         out_q    <= '0;
         imask_q  <= {gpio_N{IMASK_RST}};
         ipol_q   <= '0;
         ilat_q   <= '0;
         irq_q    <= 1'b0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         dir_q    <= dir_d;
         out_q    <= out_d;
         imask_q  <= imask_d;
         ipol_q   <= ipol_d;
         ilat_q   <= ilat_d;
         irq_q    <= irq_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
      end
   end

   assign gpio_reg_rdata  = rdata_q;
   assign gpio_reg_rvalid = rvalid_q;
   assign gpio_out        = out_q;
   assign gpio_en         = dir_q;
   assign gpio_ilat       = ilat_q;
   assign gpio_irq        = irq_q;

endmodule

// File: tb/tb_mcse_gpio_responder.sv
// Scoreboard bench for mcse_gpio_responder: directed register scenarios
// followed by randomized traffic against a behavioural model.
module tb_mcse_gpio_responder;

   localparam int N  = 32;
   localparam int AW = 32;
   localparam int PW = 2*AW+40;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          acc = 1'b0;
   logic [PW-1:0] pkt = '0;
   logic [N-1:0]  gin = '0;
   logic [N-1:0]  rdata, gout, gen, gilat;
   logic          rvalid, irq;

   always #5 clk = ~clk;

   mcse_gpio_responder #(.gpio_N(N), .gpio_AW(AW), .gpio_PW(PW)) dut (
      .clk             (clk),
      .rst             (rst),
      .gpio_reg_access (acc),
      .gpio_reg_packet (pkt),
      .gpio_reg_rdata  (rdata),
      .gpio_reg_rvalid (rvalid),
      .gpio_in         (gin),
      .gpio_out        (gout),
      .gpio_en         (gen),
      .gpio_ilat       (gilat),
      .gpio_irq        (irq)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state, as visible after the most recent edge
   logic [N-1:0] m_dir = '0, m_out = '0, m_ipol = '0, m_ilat = '0;
   logic [N-1:0] m_imask = '1, m_rdata = '0;
   logic         m_irq = 1'b0, m_rvalid = 1'b0;
   logic [N-1:0] smp[$];
   int           nsmp = 0;
   logic [N-1:0] exp_q[$];

   function automatic void chk(string nm, logic [N-1:0] act,
                               logic [N-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   // advance the model across one clock edge using the driven inputs
   function automatic void model_step();
      logic           w;
      logic [AW-1:0]  a;
      logic [N-1:0]   d, s2, s3, hit, rv, clr;
      logic           irq_n;
      bit             mapped;
      w = pkt[0];
      a = pkt[8 +: AW];
      d = pkt[AW+8 +: N];
      if (rst) begin
         m_dir = '0; m_out = '0; m_ipol = '0; m_ilat = '0;
         m_imask = '1; m_rdata = '0; m_irq = 1'b0; m_rvalid = 1'b0;
         smp.delete();
         nsmp = 0;
         return;
      end
      s2 = (nsmp >= 2) ? smp[1] : '0;
      s3 = (nsmp >= 3) ? smp[2] : '0;
      hit = '0;
      if (nsmp >= 3)
         for (int i = 0; i < N; i++)
            if (s2[i] != s3[i] && s2[i] == m_ipol[i]) hit[i] = 1'b1;
      irq_n = |(m_ilat & ~m_imask);
      mapped = (a < 256);
      rv = '0;
      clr = '0;
      if (mapped)
         case (a[7:0])
            8'h00: rv = m_dir;
            8'h04: rv = m_out;
            8'h08: rv = s2;
            8'h0C: rv = m_imask;
            8'h10: rv = m_ipol;
            8'h14: rv = m_ilat;
            default: rv = '0;
         endcase
      m_rvalid = acc && !w;
      if (acc && !w) begin
         m_rdata = rv;
         exp_q.push_back(rv);
      end
      if (acc && w && mapped)
         case (a[7:0])
            8'h00: m_dir = d;
            8'h04: m_out = d;
            8'h0C: m_imask = d;
            8'h10: m_ipol = d;
            8'h14: clr = d;
            8'h18: m_out = m_out | d;
            8'h1C: m_out = m_out & ~d;
            default: ;
         endcase
      m_ilat = (m_ilat & ~clr) | hit;
      m_irq = irq_n;
      smp.push_front(gin);
      if (smp.size() > 3) void'(smp.pop_back());
      if (nsmp < 3) nsmp++;
   endfunction

   task automatic drive(input bit r, input bit a, input bit w,
                        input logic [AW-1:0] ad, input logic [N-1:0] d);
      logic [6:0] ctrl;
      ctrl = 7'($urandom());
      rst = r;
      acc = a;
      pkt = {32'($urandom()), d, ad, ctrl, w};
      model_step();
      @(negedge clk);
   endtask

   task automatic wr(input logic [AW-1:0] ad, input logic [N-1:0] d);
      drive(1'b0, 1'b1, 1'b1, ad, d);
   endtask

   task automatic rd(input logic [AW-1:0] ad);
      drive(1'b0, 1'b1, 1'b0, ad, 32'($urandom()));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         drive(1'b0, 1'b0, 1'($urandom()), 32'($urandom()),
               32'($urandom()));
   endtask

   // monitor: compare every cycle, pop the scoreboard on each rvalid
   always @(posedge clk) begin
      #1;
      chk("rvalid", {31'b0, rvalid}, {31'b0, m_rvalid});
      if (rvalid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_unexpected: got rvalid with rdata %h", rdata);
         end else begin
            chk("sb_rdata", rdata, exp_q.pop_front());
         end
      end
      chk("rdata_hold", rdata, m_rdata);
      chk("gpio_en", gen, m_dir);
      chk("gpio_out", gout, m_out);
      chk("gpio_ilat", gilat, m_ilat);
      chk("gpio_irq", {31'b0, irq}, {31'b0, m_irq});
   end

   initial begin
      logic [AW-1:0] ad;
      int r;
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b0, '0, '0);
      drive(1'b1, 1'b0, 1'b0, '0, '0);
      chk("rst_en", gen, 32'h0);
      chk("rst_out", gout, 32'h0);
      chk("rst_ilat", gilat, 32'h0);
      chk("rst_irq", {31'b0, irq}, 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      rd(32'h0C);
      chk("rst_imask", rdata, 32'hFFFF_FFFF);

      wr(32'h00, 32'h0000_00FF);
      chk("dir_en", gen, 32'h0000_00FF);
      rd(32'h00);
      chk("dir_rvalid", {31'b0, rvalid}, 32'h1);
      chk("dir_rdata", rdata, 32'h0000_00FF);
      idle(1);
      chk("wr_no_rvalid", {31'b0, rvalid}, 32'h0);

      wr(32'h04, 32'hF0F0_0000);
      wr(32'h18, 32'h0000_000F);
      wr(32'h1C, 32'hF000_0000);
      chk("out_setclr", gout, 32'h00F0_000F);

      gin = '0;
      wr(32'h10, 32'h0000_0008);
      wr(32'h0C, 32'hFFFF_FFF7);
      idle(3);
      gin[3] = 1'b1;
      idle(3);
      chk("edge_ilat", gilat, 32'h8);
      idle(1);
      chk("edge_irq", {31'b0, irq}, 32'h1);
      wr(32'h14, 32'h8);
      chk("w1c_ilat", gilat, 32'h0);
      idle(1);
      chk("w1c_irq", {31'b0, irq}, 32'h0);

      gin[3] = 1'b0;
      idle(4);
      gin[3] = 1'b1;
      idle(3);
      chk("relatch", gilat, 32'h8);
      gin[3] = 1'b0;
      idle(4);
      gin[3] = 1'b1;
      idle(2);
      wr(32'h14, 32'h8);
      chk("w1c_vs_edge", gilat & 32'h8, 32'h8);
      wr(32'h14, 32'h8);
      chk("w1c_after", gilat, 32'h0);

      rd(32'h0000_0108);
      chk("unmap_rvalid", {31'b0, rvalid}, 32'h1);
      chk("unmap_rdata", rdata, 32'h0);
      wr(32'h0000_0108, 32'hFFFF_FFFF);
      wr(32'h0000_0100, 32'hFFFF_FFFF);
      wr(32'h0000_0020, 32'hFFFF_FFFF);
      chk("unmap_en", gen, 32'h0000_00FF);
      chk("unmap_out", gout, 32'h00F0_000F);
      rd(32'h0C);
      chk("unmap_imask", rdata, 32'hFFFF_FFF7);
      rd(32'h18);
      chk("outset_rd", rdata, 32'h0);

      rd(32'h00);
      drive(1'b1, 1'b1, 1'b0, 32'h00, '0);
      chk("rstrd_rvalid", {31'b0, rvalid}, 32'h0);
      chk("rstrd_rdata", rdata, 32'h0);
      chk("rstrd_en", gen, 32'h0);
      chk("rstrd_out", gout, 32'h0);
      chk("rstrd_irq", {31'b0, irq}, 32'h0);
      gin = '1;
      wr(32'h10, 32'hFFFF_FFFF);
      chk("rstrd_drop", {31'b0, rvalid}, 32'h0);
      idle(4);
      chk("no_rst_edge", gilat, 32'h0);

      for (int c = 0; c < 3000; c++) begin
         if (($urandom() % 16) < 4) gin = gin ^ 32'($urandom());
         r = int'($urandom() % 16);
         if (r < 12)      ad = 32'(($urandom() % 8) * 4);
         else if (r < 14) ad = 32'($urandom() % 256);
         else             ad = 32'($urandom());
         if (($urandom() % 300) == 0)
            drive(1'b1, 1'($urandom()), 1'($urandom()), ad,
                  32'($urandom()));
         else
            drive(1'b0, ($urandom() % 10) < 6, 1'($urandom()), ad,
                  32'($urandom()));
      end
      idle(3);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL sb_drain: got %0d pending reads expected 0",
                  exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
